// File: rtl/mdv_stream_if.sv
// Microdrive stream bus: RAM word port plus the byte-register side seen by the ZX8302.
interface mdv_stream_if;
  logic [16:0] mem_addr;
  logic [15:0] mem_data;
  logic        rd_ack;
  logic        gap;
  logic        rx_ready;
  logic        overrun;
  logic [7:0]  dout;

  modport master (
    output mem_addr,
    input  mem_data,
    input  rd_ack,
    output gap,
    output rx_ready,
    output overrun,
    output dout
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    output rd_ack,
    input  gap,
    input  rx_ready,
    input  overrun,
    input  dout
  );
endinterface

// File: rtl/mdv_stream.sv
// Microdrive tape emulator: plays the cartridge image held in sync RAM as an endless
// loop of sectors (header gap, header bytes, data gap, data bytes) while the motor runs.
module mdv_stream #(
  parameter int HDR_LEN    = 14,
  parameter int DATA_LEN   = 528,
  parameter int BYTE_TICKS = 64,
  parameter int GAP_TICKS  = 2800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             sel,
  input  logic             reverse,
  input  logic             download,
  input  logic [7:0]       sectors,
  mdv_stream_if.master     bus
);

  localparam int TICK_MAX = (GAP_TICKS > BYTE_TICKS) ? GAP_TICKS : BYTE_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam int CNT_MAX  = (DATA_LEN > HDR_LEN) ? DATA_LEN : HDR_LEN;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [TICK_W-1:0] BYTE_LAST = TICK_W'(BYTE_TICKS - 1);
  localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP_H = 3'd1,
    ST_HDR   = 3'd2,
    ST_GAP_D = 3'd3,
    ST_DATA  = 3'd4
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [TICK_W-1:0]   tick_r, tick_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [17:0]         ptr_r, ptr_nxt_s;
  logic [7:0]          sector_r, sector_nxt_s;
  logic                gap_r, gap_nxt_s;
  logic                rx_ready_r, rx_ready_nxt_s;
  logic                overrun_r, overrun_nxt_s;
  logic [7:0]          dout_r, dout_nxt_s;
  logic [16:0]         mem_addr_r;

  logic                advance_s;
  logic                byte_end_s;
  logic                latch_s;
  logic [7:0]          byte_s;

  // Tape only moves on a timing tick with the motor on and a cartridge present;
  // an empty drive (sectors==0) is handled separately by the next-state logic.
  assign advance_s  = ce & sel & (sectors != 8'd0);
  assign byte_end_s = (tick_r == BYTE_LAST);
  assign latch_s    = advance_s & byte_end_s & ((state_r == ST_HDR) | (state_r == ST_DATA));
  assign byte_s     = (ptr_r[0] ^ reverse) ? bus.mem_data[15:8] : bus.mem_data[7:0];

  // State register; download behaves like a synchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else if (download) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: sector sequencing, evaluated only on ce.
  always_comb begin
    state_nxt_s = state_r;
    if (ce && (sectors == 8'd0)) begin
      state_nxt_s = ST_IDLE;
    end else if (advance_s) begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_GAP_H;
        ST_GAP_H: state_nxt_s = (tick_r == GAP_LAST) ? ST_HDR : ST_GAP_H;
        ST_HDR:   state_nxt_s = (byte_end_s && (cnt_r == HDR_LAST)) ? ST_GAP_D : ST_HDR;
        ST_GAP_D: state_nxt_s = (tick_r == GAP_LAST) ? ST_DATA : ST_GAP_D;
        ST_DATA:  state_nxt_s = (byte_end_s && (cnt_r == DATA_LAST)) ? ST_GAP_H : ST_DATA;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output/datapath logic: tick, byte counters, tape pointer and register-side flags.
  always_comb begin
    tick_nxt_s   = tick_r;
    cnt_nxt_s    = cnt_r;
    ptr_nxt_s    = ptr_r;
    sector_nxt_s = sector_r;
    if (advance_s) begin
      case (state_r)
        ST_IDLE: begin
          tick_nxt_s = {TICK_W{1'b0}};
        end
        ST_GAP_H, ST_GAP_D: begin
          if (tick_r == GAP_LAST) begin
            tick_nxt_s = {TICK_W{1'b0}};
            cnt_nxt_s  = {CNT_W{1'b0}};
          end else begin
            tick_nxt_s = tick_r + TICK_W'(1);
          end
        end
        ST_HDR, ST_DATA: begin
          if (byte_end_s) begin
            tick_nxt_s = {TICK_W{1'b0}};
            cnt_nxt_s  = cnt_r + CNT_W'(1);
            ptr_nxt_s  = ptr_r + 18'd1;
            if ((state_r == ST_DATA) && (cnt_r == DATA_LAST)) begin
              // Running pointer wraps with the sector count, so no multiply is needed.
              if (sector_r >= (sectors - 8'd1)) begin
                sector_nxt_s = 8'd0;
                ptr_nxt_s    = 18'd0;
              end else begin
                sector_nxt_s = sector_r + 8'd1;
              end
            end else begin
              sector_nxt_s = sector_r;
            end
          end else begin
            tick_nxt_s = tick_r + TICK_W'(1);
          end
        end
        default: begin
          tick_nxt_s = {TICK_W{1'b0}};
        end
      endcase
    end else begin
      tick_nxt_s = tick_r;
    end

    // Gap is only visible while the motor runs; rises together with entry into a gap state.
    gap_nxt_s = sel & ((state_nxt_s == ST_GAP_H) | (state_nxt_s == ST_GAP_D));

    // A byte latch beats a simultaneous CPU read, so a fresh byte is never dropped silently.
    dout_nxt_s     = dout_r;
    rx_ready_nxt_s = rx_ready_r;
    overrun_nxt_s  = overrun_r;
    if (latch_s) begin
      dout_nxt_s     = byte_s;
      rx_ready_nxt_s = 1'b1;
      overrun_nxt_s  = (rx_ready_r & ~bus.rd_ack) ? 1'b1 : overrun_r;
    end else if (bus.rd_ack) begin
      rx_ready_nxt_s = 1'b0;
      overrun_nxt_s  = 1'b0;
    end else begin
      rx_ready_nxt_s = rx_ready_r;
    end
  end

  // Datapath and output registers; download clears everything like reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_r     <= {TICK_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      ptr_r      <= 18'd0;
      sector_r   <= 8'd0;
      gap_r      <= 1'b0;
      rx_ready_r <= 1'b0;
      overrun_r  <= 1'b0;
      dout_r     <= 8'h00;
      mem_addr_r <= 17'd0;
    end else if (download) begin
      tick_r     <= {TICK_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      ptr_r      <= 18'd0;
      sector_r   <= 8'd0;
      gap_r      <= 1'b0;
      rx_ready_r <= 1'b0;
      overrun_r  <= 1'b0;
      dout_r     <= 8'h00;
      mem_addr_r <= 17'd0;
    end else begin
      tick_r     <= tick_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ptr_r      <= ptr_nxt_s;
      sector_r   <= sector_nxt_s;
      gap_r      <= gap_nxt_s;
      rx_ready_r <= rx_ready_nxt_s;
      overrun_r  <= overrun_nxt_s;
      dout_r     <= dout_nxt_s;
      mem_addr_r <= ptr_nxt_s[17:1];
    end
  end

  assign bus.mem_addr = mem_addr_r;
  assign bus.gap      = gap_r;
  assign bus.rx_ready = rx_ready_r;
  assign bus.overrun  = overrun_r;
  assign bus.dout     = dout_r;

endmodule
